// File: rtl/ahb_param_arbiter_if.sv
// Request/grant signals between the AHB masters and the parametrised arbiter.
// The slave modport is the arbiter's view; the master modport is the request side.
interface ahb_param_arbiter_if #(
   parameter int NUM_MASTERS = 4,
   parameter int MW          = ($clog2(NUM_MASTERS) > 1) ? $clog2(NUM_MASTERS) : 1
);
   logic [NUM_MASTERS-1:0] HBUSREQ;
   logic [NUM_MASTERS-1:0] HLOCK;
   logic                   HREADY;
   logic [1:0]             HTRANS;
   logic [2:0]             HBURST;
   logic                   PRIO_MODE;
   logic [NUM_MASTERS-1:0] HGRANT;
   logic [MW-1:0]          HMASTER;
   logic                   HMASTLOCK;

   modport slave (
      input  HBUSREQ, HLOCK, HREADY, HTRANS, HBURST, PRIO_MODE,
      output HGRANT, HMASTER, HMASTLOCK
   );

   modport master (
      output HBUSREQ, HLOCK, HREADY, HTRANS, HBURST, PRIO_MODE,
      input  HGRANT, HMASTER, HMASTLOCK
   );
endinterface

// File: rtl/ahb_param_arbiter.sv
// Parametrised AHB arbiter: round-robin or fixed priority, locked sequences, burst tracking.
// Define AHB_ARB_INCR_LIMIT_EN to force re-arbitration after MAX_INCR_BEATS beats of an INCR burst.
module ahb_param_arbiter #(
   parameter int NUM_MASTERS    = 4,
   parameter int DEFAULT_MASTER = 0,
   parameter int MAX_INCR_BEATS = 16
) (
   input logic HCLK,
   input logic HRESETn,
   ahb_param_arbiter_if.slave io_ahb
);
   localparam int MW = ($clog2(NUM_MASTERS) > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam logic [MW-1:0]          DEF_IDX   = MW'(DEFAULT_MASTER);
   localparam logic [MW-1:0]          LAST_IDX  = MW'(NUM_MASTERS - 1);
   localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

   typedef enum logic [1:0] {
      ARB       = 2'd0,
      BURST_FIX = 2'd1,
      BURST_INC = 2'd2,
      LOCKED    = 2'd3
   } state_t;

   if (NUM_MASTERS < 2 || NUM_MASTERS > 16) begin : g_badNumMasters
      $error("NUM_MASTERS must be 2..16");
   end
   if (DEFAULT_MASTER < 0 || DEFAULT_MASTER >= NUM_MASTERS) begin : g_badDefault
      $error("DEFAULT_MASTER must be below NUM_MASTERS");
   end
   if (MAX_INCR_BEATS < 2 || MAX_INCR_BEATS > 1024) begin : g_badIncrLimit
      $error("MAX_INCR_BEATS must be 2..1024");
   end

   state_t                 r_state, w_stateNext;
   logic [MW-1:0]          r_grantIdx, w_grantIdxNext;
   logic [MW-1:0]          r_rrLast, w_rrLastNext;
   logic [MW-1:0]          r_hmaster;
   logic [MW-1:0]          w_winner, w_rrIdx;
   logic [NUM_MASTERS-1:0] r_grant, w_cand, w_ownerMask;
   logic [3:0]             r_remaining, w_remainingNext, w_burstLen;
   logic                   r_hmastlock;
   logic                   w_ready, w_beat, w_newBurst, w_ownReq, w_ownLock;
   logic                   w_limitHit, w_arbPoint, w_found;

   assign w_ready    = io_ahb.HREADY;
   assign w_beat     = io_ahb.HREADY && io_ahb.HTRANS[1];
   assign w_newBurst = io_ahb.HREADY && (io_ahb.HTRANS == 2'b10) && (io_ahb.HBURST != 3'b000);
   assign w_ownReq   = io_ahb.HBUSREQ[r_grantIdx];
   assign w_ownLock  = io_ahb.HLOCK[r_grantIdx];

`ifdef AHB_ARB_INCR_LIMIT_EN
   localparam int CW = $clog2(MAX_INCR_BEATS + 1);
   logic [CW-1:0] r_incrCnt, w_incrCntNext;

   // The beat that brings the count to the limit ends the owner's tenure unless it is locked.
   assign w_limitHit = (r_state == BURST_INC) && w_beat && !w_ownLock &&
                       (r_incrCnt == CW'(MAX_INCR_BEATS - 1));
`else
   assign w_limitHit = 1'b0;
`endif

   // Winner search; a limit-forced handover in round-robin mode skips the owner when others wait.
   always_comb begin
      w_ownerMask = NUM_MASTERS'(1) << r_grantIdx;
      w_cand      = io_ahb.HBUSREQ;
      if (w_limitHit && !io_ahb.PRIO_MODE && ((io_ahb.HBUSREQ & ~w_ownerMask) != '0))
         w_cand = io_ahb.HBUSREQ & ~w_ownerMask;
      w_winner = DEF_IDX;
      w_found  = 1'b0;
      w_rrIdx  = '0;
      if (io_ahb.PRIO_MODE) begin
         for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!w_found && w_cand[MW'(i)]) begin
               w_winner = MW'(i);
               w_found  = 1'b1;
            end
         end
      end else begin
         for (int k = 1; k <= NUM_MASTERS; k++) begin
            w_rrIdx = MW'((int'(r_rrLast) + k) % NUM_MASTERS);
            if (!w_found && w_cand[w_rrIdx]) begin
               w_winner = w_rrIdx;
               w_found  = 1'b1;
            end
         end
      end
   end

   always_comb begin
      case (io_ahb.HBURST[2:1])
         2'b01:   w_burstLen = 4'd3;
         2'b10:   w_burstLen = 4'd7;
         default: w_burstLen = 4'd15;
      endcase
   end

   // Next-state: decide whether this edge is an arbitration point, then lock/burst/handover.
   always_comb begin
      w_stateNext     = r_state;
      w_grantIdxNext  = r_grantIdx;
      w_rrLastNext    = r_rrLast;
      w_remainingNext = r_remaining;
      w_arbPoint      = 1'b0;
`ifdef AHB_ARB_INCR_LIMIT_EN
      w_incrCntNext   = r_incrCnt;
`endif
      case (r_state)
         ARB: w_arbPoint = w_ready;
         BURST_FIX: begin
            if (w_beat) begin
               w_remainingNext = r_remaining - 4'd1;
               if (r_remaining == 4'd1)
                  w_arbPoint = 1'b1;
            end
         end
         BURST_INC: begin
            if (w_ready && (!w_ownReq || w_limitHit)) begin
               w_arbPoint = 1'b1;
            end else if (w_beat) begin
`ifdef AHB_ARB_INCR_LIMIT_EN
               w_incrCntNext = r_incrCnt + CW'(1);
`endif
            end
         end
         LOCKED: w_arbPoint = w_ready && !w_ownLock;
         default: w_arbPoint = w_ready;
      endcase

      if (w_arbPoint) begin
         if (w_ownLock && w_ownReq) begin
            w_stateNext = LOCKED;
         end else if (w_newBurst) begin
            if (io_ahb.HBURST == 3'b001) begin
               w_stateNext = BURST_INC;
`ifdef AHB_ARB_INCR_LIMIT_EN
               w_incrCntNext = '0;
`endif
            end else begin
               w_stateNext     = BURST_FIX;
               w_remainingNext = w_burstLen;
            end
         end else begin
            w_stateNext    = ARB;
            w_grantIdxNext = w_winner;
            if (io_ahb.HBUSREQ[w_winner])
               w_rrLastNext = w_winner;
         end
      end
   end

   // State, grant and address-phase ownership registers.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state     <= ARB;
         r_grantIdx  <= DEF_IDX;
         r_grant     <= DEF_GRANT;
         r_rrLast    <= LAST_IDX;
         r_remaining <= 4'd0;
         r_hmaster   <= DEF_IDX;
         r_hmastlock <= 1'b0;
      end else begin
         r_state     <= w_stateNext;
         r_grantIdx  <= w_grantIdxNext;
         r_grant     <= NUM_MASTERS'(1) << w_grantIdxNext;
         r_rrLast    <= w_rrLastNext;
         r_remaining <= w_remainingNext;
         if (w_ready) begin
            r_hmaster   <= r_grantIdx;
            r_hmastlock <= w_ownLock;
         end
      end
   end

`ifdef AHB_ARB_INCR_LIMIT_EN
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)
         r_incrCnt <= '0;
      else
         r_incrCnt <= w_incrCntNext;
   end
`endif

   assign io_ahb.HGRANT    = r_grant;
   assign io_ahb.HMASTER   = r_hmaster;
   assign io_ahb.HMASTLOCK = r_hmastlock;
endmodule

// File: tb/tb_ahb_param_arbiter.sv
// Directed scoreboard bench for ahb_param_arbiter with four masters, default master 0.
module tb_ahb_param_arbiter;
   localparam int NM = 4;
   localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;

   logic HCLK    = 1'b0;
   logic HRESETn = 1'b0;

   ahb_param_arbiter_if #(.NUM_MASTERS(NM)) bus ();

   ahb_param_arbiter #(
      .NUM_MASTERS   (NM),
      .DEFAULT_MASTER(0),
      .MAX_INCR_BEATS(4)
   ) dut (
      .HCLK   (HCLK),
      .HRESETn(HRESETn),
      .io_ahb (bus)
   );

   always #5 HCLK = ~HCLK;

   typedef struct {
      int         cyc;
      logic [3:0] grant;
      logic [1:0] master;
      logic       lock;
      string      tag;
   } expEntry_t;

   expEntry_t scoreQ[$];
   expEntry_t monEntry;
   int cycleCount = 0;
   int total = 0;
   int bad = 0;
   int mdlGrant = 0;
   logic [1:0] mdlMaster = 2'd0;
   logic       mdlLock = 1'b0;

   // Cycle index used to line expected entries up with the edge they describe.
   always @(posedge HCLK) cycleCount++;

   task automatic checkOutput(input string tag, input logic [3:0] actual, input logic [3:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %b, expected %b (cycle %0d)", tag, actual, expected, cycleCount);
      end
   endtask

   // Monitor: pops every entry due by this cycle and compares on the falling edge.
   always @(negedge HCLK) begin
      while (scoreQ.size() > 0 && scoreQ[0].cyc <= cycleCount) begin
         monEntry = scoreQ.pop_front();
         checkOutput({monEntry.tag, ".HGRANT"}, bus.HGRANT, monEntry.grant);
         checkOutput({monEntry.tag, ".HMASTER"}, {2'b00, bus.HMASTER}, {2'b00, monEntry.master});
         checkOutput({monEntry.tag, ".HMASTLOCK"}, {3'b000, bus.HMASTLOCK}, {3'b000, monEntry.lock});
      end
   end

   task automatic pushExpected(input string tag, input int cyc);
      expEntry_t e;
      e.cyc    = cyc;
      e.grant  = 4'b0001 << mdlGrant;
      e.master = mdlMaster;
      e.lock   = mdlLock;
      e.tag    = tag;
      scoreQ.push_back(e);
   endtask

   // Drive one edge's inputs; expGrant is the hand-computed winner visible after that edge.
   task automatic applyStimulus(input string tag, input logic [3:0] req, input logic [3:0] lock,
                                input logic ready, input logic [1:0] trans, input logic [2:0] burst,
                                input logic prio, input int expGrant);
      @(posedge HCLK);
      #1;
      bus.HBUSREQ   = req;
      bus.HLOCK     = lock;
      bus.HREADY    = ready;
      bus.HTRANS    = trans;
      bus.HBURST    = burst;
      bus.PRIO_MODE = prio;
      if (ready) begin
         mdlMaster = 2'(mdlGrant);
         mdlLock   = lock[mdlGrant];
      end
      mdlGrant = expGrant;
      pushExpected(tag, cycleCount + 1);
   endtask

   task automatic driveIdle();
      bus.HBUSREQ   = 4'b0000;
      bus.HLOCK     = 4'b0000;
      bus.HREADY    = 1'b0;
      bus.HTRANS    = IDLE;
      bus.HBURST    = 3'b000;
      bus.PRIO_MODE = 1'b0;
   endtask

   // Asserts reset mid-cycle, after the pending edge has been checked, then releases it.
   task automatic resetPulse(input string tag);
      @(posedge HCLK);
      @(negedge HCLK);
      #2;
      HRESETn = 1'b0;
      driveIdle();
      mdlGrant  = 0;
      mdlMaster = 2'd0;
      mdlLock   = 1'b0;
      #1;
      checkOutput({tag, ".asyncGrant"}, bus.HGRANT, 4'b0001);
      checkOutput({tag, ".asyncMaster"}, {2'b00, bus.HMASTER}, 4'b0000);
      pushExpected({tag, ".hold"}, cycleCount + 1);
      @(negedge HCLK);
      #2;
      HRESETn = 1'b1;
      pushExpected({tag, ".release"}, cycleCount + 1);
   endtask

   initial begin
      driveIdle();
      resetPulse("init");
      applyStimulus("idleDefault", 4'b0000, 4'b0000, 1'b1, IDLE, 3'b000, 1'b0, 0);

      applyStimulus("rr0", 4'b1111, 4'b0000, 1'b1, NONSEQ, 3'b000, 1'b0, 0);
      applyStimulus("rr1", 4'b1111, 4'b0000, 1'b1, NONSEQ, 3'b000, 1'b0, 1);
      applyStimulus("rr2", 4'b1111, 4'b0000, 1'b1, NONSEQ, 3'b000, 1'b0, 2);
      applyStimulus("rr3", 4'b1111, 4'b0000, 1'b1, NONSEQ, 3'b000, 1'b0, 3);
      applyStimulus("rr4", 4'b1111, 4'b0000, 1'b1, NONSEQ, 3'b000, 1'b0, 0);

      applyStimulus("toM1", 4'b0110, 4'b0000, 1'b1, IDLE, 3'b000, 1'b0, 1);
      applyStimulus("incr4Beat1", 4'b0110, 4'b0000, 1'b1, NONSEQ, 3'b011, 1'b0, 1);
      for (int w = 0; w < 3; w++)
         applyStimulus("incr4Wait", 4'b0110, 4'b0000, 1'b0, SEQ, 3'b011, 1'b0, 1);
      applyStimulus("incr4Beat2", 4'b0110, 4'b0000, 1'b1, SEQ, 3'b011, 1'b0, 1);
      applyStimulus("incr4Beat3", 4'b0110, 4'b0000, 1'b1, SEQ, 3'b011, 1'b0, 1);
      applyStimulus("incr4Beat4", 4'b0110, 4'b0000, 1'b1, SEQ, 3'b011, 1'b0, 2);

      applyStimulus("prioA", 4'b0110, 4'b0000, 1'b1, IDLE, 3'b000, 1'b1, 1);
      applyStimulus("prioB", 4'b0111, 4'b0000, 1'b1, IDLE, 3'b000, 1'b1, 0);

      applyStimulus("lockGrant", 4'b1000, 4'b1000, 1'b1, IDLE, 3'b000, 1'b0, 3);
      applyStimulus("lockXfer1", 4'b1111, 4'b1000, 1'b1, NONSEQ, 3'b000, 1'b0, 3);
      applyStimulus("lockXfer2", 4'b1111, 4'b1000, 1'b1, NONSEQ, 3'b000, 1'b0, 3);
      applyStimulus("unlock", 4'b1111, 4'b0000, 1'b1, IDLE, 3'b000, 1'b0, 0);

      applyStimulus("incrStart", 4'b0101, 4'b0000, 1'b1, NONSEQ, 3'b001, 1'b0, 0);
      applyStimulus("incrSeq1", 4'b0101, 4'b0000, 1'b1, SEQ, 3'b001, 1'b0, 0);
      applyStimulus("incrBusy", 4'b0101, 4'b0000, 1'b1, BUSY, 3'b001, 1'b0, 0);
      applyStimulus("incrSeq2", 4'b0101, 4'b0000, 1'b1, SEQ, 3'b001, 1'b0, 0);
      applyStimulus("incrSeq3", 4'b0101, 4'b0000, 1'b1, SEQ, 3'b001, 1'b0, 0);
`ifdef AHB_ARB_INCR_LIMIT_EN
      applyStimulus("incrSeq4", 4'b0101, 4'b0000, 1'b1, SEQ, 3'b001, 1'b0, 2);
`else
      applyStimulus("incrSeq4", 4'b0101, 4'b0000, 1'b1, SEQ, 3'b001, 1'b0, 0);
`endif
      applyStimulus("incrRelease", 4'b0100, 4'b0000, 1'b1, IDLE, 3'b000, 1'b0, 2);

      applyStimulus("incr8Start", 4'b0100, 4'b0000, 1'b1, NONSEQ, 3'b101, 1'b0, 2);
      applyStimulus("incr8Seq1", 4'b0100, 4'b0000, 1'b1, SEQ, 3'b101, 1'b0, 2);
      applyStimulus("incr8Seq2", 4'b0100, 4'b0000, 1'b1, SEQ, 3'b101, 1'b0, 2);
      resetPulse("midBurst");
      applyStimulus("afterReset", 4'b0010, 4'b0000, 1'b1, SEQ, 3'b101, 1'b0, 1);
      applyStimulus("rrAfterReset", 4'b1010, 4'b0000, 1'b1, IDLE, 3'b000, 1'b0, 3);
      applyStimulus("noReqDefault", 4'b0000, 4'b0000, 1'b1, IDLE, 3'b000, 1'b0, 0);

      applyStimulus("wrap4Start", 4'b0011, 4'b0000, 1'b1, NONSEQ, 3'b010, 1'b0, 0);
      applyStimulus("wrap4Beat2", 4'b0011, 4'b0000, 1'b1, SEQ, 3'b010, 1'b0, 0);
      applyStimulus("wrap4Beat3", 4'b0011, 4'b0000, 1'b1, SEQ, 3'b010, 1'b0, 0);
      applyStimulus("wrap4LastLocked", 4'b0011, 4'b0001, 1'b1, SEQ, 3'b010, 1'b0, 0);
      applyStimulus("wrap4Held", 4'b0011, 4'b0001, 1'b1, IDLE, 3'b000, 1'b0, 0);
      applyStimulus("wrap4Unlock", 4'b0010, 4'b0000, 1'b1, IDLE, 3'b000, 1'b0, 1);
      applyStimulus("tail", 4'b0000, 4'b0000, 1'b0, IDLE, 3'b000, 1'b0, 1);

      for (int n = 0; n < 10 && scoreQ.size() > 0; n++)
         @(posedge HCLK);
      while (scoreQ.size() > 0) begin
         monEntry = scoreQ.pop_front();
         total++;
         bad++;
         $display("[TB] FAIL %s: never checked, expected grant %b", monEntry.tag, monEntry.grant);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end
endmodule
